reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
- Owns the configuration register bank and shares its single write port between two requesters: the SPI register interface and an on-chip host.
- SPI writes arrive as single-cycle pulses that cannot be stalled, so they are buffered in a small FIFO.
- The host uses a req/gnt handshake for reads and writes.
- Round-robin arbitration; per-write event pulses and a sticky overflow flag are exported.

Parameters:
- NUM_REGS, 8, number of registers in the bank.
- WIDTH, 8, register width in bits.
- ADDR_WIDTH, 3, address width; must equal clog2(NUM_REGS).
- FIFO_DEPTH, 2, SPI write buffer entries (power of two, >=2).

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- ena  input  1  block enable; low freezes arbitration and buffering.
- spi_addr  input  ADDR_WIDTH  SPI register address.
- spi_wdata  input  WIDTH  SPI write data.
- spi_wvld  input  1  SPI write strobe, one-cycle pulse.
- spi_rdata  output  WIDTH  combinational mem[spi_addr].
- host_req  input  1  host access request, held until granted.
- host_we  input  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  input  ADDR_WIDTH  host address.
- host_wdata  input  WIDTH  host write data.
- host_gnt  output  1  combinational; access accepted at this clock edge.
- host_rvld  output  1  read data valid, one cycle after a granted read.
- host_rdata  output  WIDTH  registered read data.
- config_regs  output  NUM_REGS*WIDTH  flat bank contents; reg i at bits [i*WIDTH +: WIDTH].
- wr_event  output  1  pulse, one cycle after any bank write.
- wr_event_src  output  1  0 = SPI, 1 = host; valid with wr_event.
- wr_event_addr  output  ADDR_WIDTH  address written; valid with wr_event.
- ovf_sticky  output  1  set when an SPI write is dropped because the FIFO is full.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset:
  - All registers 0; FIFO empty.
  - host_rvld, host_rdata, wr_event, wr_event_src, wr_event_addr and ovf_sticky are 0.
  - Round-robin pointer last_winner = HOST, so SPI wins the first contention.
  - Reset asserted mid-operation discards FIFO contents and any pending read.
- FIFO push: spi_wvld & ena pushes {spi_addr, spi_wdata}.
  - If full and no pop occurs that cycle: the entry is dropped and ovf_sticky is set.
  - If full and a pop occurs that same cycle: the push is accepted, with no overflow.
  - spi_wvld while ena=0 is ignored without setting overflow.
- Arbitration is evaluated every cycle with ena=1; candidates are FIFO non-empty and host_req.
  - One candidate: it wins.
  - Both candidates: the one that is not last_winner wins.
  - last_winner updates only on a grant.
  - With ena=0: no grant, host_gnt=0, no pop, bank holds.
- SPI win: pop the FIFO head and write mem[addr] at this edge.
- Host win: host_gnt=1 this cycle.
  - Write: mem[host_addr] updates at this edge.
  - Read: host_rdata = mem[host_addr] sampled at this edge (pre-write value), host_rvld=1 for the next cycle.
- Latency:
  - Uncontended host access is granted in the request cycle.
  - Contended host access waits at most 1 cycle per queued SPI entry ahead of it, and never more than 1 consecutive loss.
  - SPI FIFO entries are written in order.
- Events: wr_event pulses the cycle after each write, with src and addr registered. host_rvld and host_rdata hold 0 when no read completed in the previous cycle.
- ovf_clr and a new overflow in the same cycle: set wins.
- The bank is the only state driving config_regs (registered, no extra latency).
- spi_rdata reflects the current bank contents; pending FIFO writes are not forwarded.
- Address out of range (>= NUM_REGS when not a power of two): the write is ignored and reads return 0.

Test Plan:
- Reset, then spi_wvld with addr 3, data 0xA5 -> cycle+1 mem[3]=0xA5; config_regs[31:24]=0xA5; wr_event=1, src=0, addr=3 on cycle+2.
- host_req write addr 5, data 0x3C with FIFO empty -> host_gnt=1 same cycle; mem[5]=0x3C next cycle; wr_event src=1.
- FIFO holds 1 entry and host_req is asserted -> SPI wins first (last_winner=HOST at reset), host granted next cycle; a repeat contention alternates winners.
- Three SPI pulses on consecutive cycles while host_req holds priority -> if the third arrives with FIFO full and no pop, ovf_sticky=1 and the third write is never applied; ovf_clr -> 0.
- Host read of addr 2 (value 0x11) in the same cycle as an SPI write to addr 2 (0x22) -> host_rdata=0x11 with host_rvld; mem[2] ends at the winner-ordered value.
- ena=0 with queued SPI entry and host_req -> no host_gnt, no writes, FIFO held; ena=1 -> queued write drains. Assert rstb mid-queue -> FIFO empty, bank 0.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: config register bank whose write port is shared round-robin between buffered SPI writes and a host req/gnt port
module reg_bank_arbiter #(
    parameter int NUM_REGS   = 8,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  logic [ADDR_WIDTH-1:0]     spi_addr,
    input  logic [WIDTH-1:0]          spi_wdata,
    input  logic                      spi_wvld,
    output logic [WIDTH-1:0]          spi_rdata,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [ADDR_WIDTH-1:0]     host_addr,
    input  logic [WIDTH-1:0]          host_wdata,
    output logic                      host_gnt,
    output logic                      host_rvld,
    output logic [WIDTH-1:0]          host_rdata,
    output logic [NUM_REGS*WIDTH-1:0] config_regs,
    output logic                      wr_event,
    output logic                      wr_event_src,
    output logic [ADDR_WIDTH-1:0]     wr_event_addr,
    output logic                      ovf_sticky,
    input  logic                      ovf_clr
);
    typedef enum logic {SRC_SPI = 1'b0, SRC_HOST = 1'b1} src_e;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_WIDTH + WIDTH;
    localparam logic [ADDR_WIDTH:0] NR = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0]      mem_q [NUM_REGS];
    logic [EW-1:0]         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    src_e                  last_q, last_d;
    logic                  ovf_q, ovf_d, rvld_q, rvld_d, ev_q, ev_d, ev_src_q, ev_src_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] ev_addr_q, ev_addr_d;
    logic                  full, spi_cand, host_cand, spi_win, host_win, push, push_ok, wr_en;
    logic [ADDR_WIDTH-1:0] head_addr, wr_addr;
    logic [WIDTH-1:0]      head_data, wr_data;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    assign {head_addr, head_data} = fifo_q[rd_ptr_q];

    // Arbitration, FIFO bookkeeping and next-state of all registered outputs
    always_comb begin
        full      = cnt_q == FULL_CNT;
        spi_cand  = ena && cnt_q != '0;
        host_cand = ena && host_req;
        spi_win   = spi_cand && (!host_cand || last_q == SRC_HOST);
        host_win  = host_cand && (!spi_cand || last_q == SRC_SPI);
        push      = ena && spi_wvld;
        push_ok   = push && (!full || spi_win);
        wr_addr   = spi_win ? head_addr : host_addr;
        wr_data   = spi_win ? head_data : host_wdata;
        wr_en     = (spi_win || (host_win && host_we)) && in_range(wr_addr);
        wr_ptr_d  = wr_ptr_q + PW'(push_ok);
        rd_ptr_d  = rd_ptr_q + PW'(spi_win);
        cnt_d     = cnt_q + (PW+1)'(push_ok) - (PW+1)'(spi_win);
        last_d    = spi_win ? SRC_SPI : host_win ? SRC_HOST : last_q;
        ovf_d     = (push && full && !spi_win) || (ovf_q && !ovf_clr);
        rvld_d    = host_win && !host_we;
        rdata_d   = (rvld_d && in_range(host_addr)) ? mem_q[host_addr] : '0;
        ev_d      = wr_en;
        ev_src_d  = wr_en && host_win;
        ev_addr_d = wr_en ? wr_addr : '0;
    end

    // Control and event registers; reset discards queued writes and pending reads
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            last_q    <= SRC_HOST;
            ovf_q     <= 1'b0;
            rvld_q    <= 1'b0;
            rdata_q   <= '0;
            ev_q      <= 1'b0;
            ev_src_q  <= 1'b0;
            ev_addr_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            rvld_q    <= rvld_d;
            rdata_q   <= rdata_d;
            ev_q      <= ev_d;
            ev_src_q  <= ev_src_d;
            ev_addr_q <= ev_addr_d;
        end
    end

    // FIFO storage needs no reset: the count alone says what is valid
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= {spi_addr, spi_wdata};
    end

    // Register bank with its single write port
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
        assign config_regs[i*WIDTH +: WIDTH] = mem_q[i];
    end

    assign spi_rdata     = in_range(spi_addr) ? mem_q[spi_addr] : '0;
    assign host_gnt      = host_win;
    assign host_rvld     = rvld_q;
    assign host_rdata    = rdata_q;
    assign wr_event      = ev_q;
    assign wr_event_src  = ev_src_q;
    assign wr_event_addr = ev_addr_q;
    assign ovf_sticky    = ovf_q;
endmodule
